jtag_scan_master: RTL and testbench
===================================

Name: jtag_scan_master

Overview:
- On-chip JTAG host-side scan engine: the initiating end of the TAP protocol that the virtual-JTAG source/probe and debug blocks respond to.
- Accepts one scan command (optional IR scan, then DR scan) and bit-bangs TCK/TMS/TDI through the IEEE 1149.1 TAP state sequence.
- Samples TDO and returns the captured DR bits.
- Used for self-test and simulation benches, and as a bridge for an embedded controller to drive the JTAG chain without the host PC.

Parameters:
- IR_W, 3, instruction register length in bits shifted per IR scan.
- DR_W, 32, maximum DR scan length; width of data in/out.
- LEN_W, 6, width of cmd_len; must satisfy 2^LEN_W > DR_W.
- DIV, 2, clk cycles per TCK half-period (>=1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine idle in Run-Test/Idle and able to accept a command.
- cmd_ir_en  in  1  1 = perform an IR scan before the DR scan.
- cmd_ir  in  IR_W  instruction, shifted LSB first.
- cmd_dr  in  DR_W  DR data, shifted LSB first.
- cmd_len  in  LEN_W  DR bits to shift; 0 = no DR scan; values above DR_W are clamped to DR_W.
- rsp_valid  out  1  one-cycle pulse when the command completes.
- rsp_dr  out  DR_W  captured TDO bits, valid with rsp_valid and held until the next rsp_valid.
- tck  out  1  JTAG clock.
- tms  out  1  JTAG mode select.
- tdi  out  1  JTAG data to target.
- tdo  in  1  JTAG data from target; already synchronous to clk.

Behaviour:
- Reset (reset_n=0 sampled at a clk edge):
  - tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_dr=0.
  - Any scan in progress is abandoned with no rsp_valid.
  - The state machine enters TLR_SEQ.
- TCK generation:
  - Each TCK pulse is DIV clk cycles low followed by DIV clk cycles high.
  - tms/tdi change only at the start of the low phase.
  - tdo is sampled on the clk edge at which tck rises.
  - When no pulse is in progress, tck idles at 0.
- TMS sequences, one TCK pulse per listed TMS value:
  - TLR_SEQ: 1,1,1,1,1,0. Ends in Run-Test/Idle, then the machine goes to IDLE.
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready:
    - latch cmd_ir_en, cmd_ir, cmd_dr and the clamped length;
    - cmd_ready drops the next cycle;
    - clear the capture register.
  - IR scan (if ir_en): TMS 1,1,0,0, then IR_W shift bits, then 1,0.
    - Shift bits carry tdi=cmd_ir[i] and TMS=0 except the last bit, which uses TMS=1 (Exit1-IR).
    - TDO during the IR scan is discarded.
  - DR scan (if len>0): TMS 1,0,0, then len shift bits with the last at TMS=1, then 1,0.
    - tdi=cmd_dr[i].
    - The TDO sampled at shift bit i is written to rsp_dr[i].
    - rsp_dr bits at positions >= len are 0.
  - If ir_en=0 and len=0: no TCK pulses are issued; rsp_valid follows 1 cycle after accept with rsp_dr=0.
- Completion:
  - rsp_valid pulses for 1 clk in the cycle after the final TCK high phase ends.
  - cmd_ready=1 in that same cycle.
  - A new command accepted in that cycle starts its first TCK low phase on the next cycle.
- tdi outside shift states is 0.
- tms is held at the value of the last pulse while idle; in IDLE this is 0.
- cmd_valid is ignored while cmd_ready=0; no queuing.
- Pulse counts for a command: (ir_en ? IR_W+6 : 0) + (len>0 ? len+5 : 0).
- Clock-cycle latency from accept to rsp_valid is that pulse count × 2·DIV + 1.

Test Plan:
- Reset release (DIV=2): exactly 6 TCK pulses with TMS 1,1,1,1,1,0; cmd_ready rises 1 cycle after the 6th high phase; tck period = 4 clk.
- Command ir_en=1, ir=3'b001, dr=32'h0000_00A5, len=8, with bench TAP model (3-bit IR, 8-bit DR loopback preloaded 8'h3C):
  - 22 TCK pulses;
  - TAP IR = 001;
  - TAP DR = 8'hA5;
  - rsp_dr = 32'h0000_003C;
  - latency 22×4+1 = 89 clk.
- tdo tied 1, ir_en=0, len=40 with DR_W=32: length clamps to 32, 37 pulses, rsp_dr = 32'hFFFF_FFFF.
- ir_en=0, len=0: no TCK edges, rsp_valid 1 cycle after accept, rsp_dr=0; ir_en=1, len=0: exactly 9 pulses, TAP IR updated, rsp_dr=0.
- Back-to-back commands: second cmd_valid held high is accepted in the rsp_valid cycle; its first tck rise occurs DIV+1 cycles later; cmd_valid asserted mid-scan has no effect.
- Assert reset_n=0 during the DR shift of a len=16 scan:
  - next cycle tck=0, tms=1, no rsp_valid;
  - after release the TLR sequence repeats;
  - a following scan completes correctly.

Source files
------------

// File: rtl/jtag_scan_master.sv
// jtag_scan_master: host-side JTAG scan engine running an optional IR scan and then a DR scan through the TAP
// Ports: clk/reset_n (sync, active-low); cmd_valid/cmd_ready with cmd_ir_en, cmd_ir, cmd_dr, cmd_len;
// rsp_valid pulse with rsp_dr (captured TDO bits); tck/tms/tdi to the target and tdo from it.
module jtag_scan_master #(
  parameter int IR_W  = 3,
  parameter int DR_W  = 32,
  parameter int LEN_W = 6,
  parameter int DIV   = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_ir_en,
  input  logic [IR_W-1:0]  cmd_ir,
  input  logic [DR_W-1:0]  cmd_dr,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             rsp_valid,
  output logic [DR_W-1:0]  rsp_dr,
  output logic             tck,
  output logic             tms,
  output logic             tdi,
  input  logic             tdo
);
  localparam int IW = (LEN_W + 2 > $clog2(IR_W + 7)) ? LEN_W + 2 : $clog2(IR_W + 7);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  typedef enum logic [1:0] {TLR, IDLE, IR, DR} state_t;
  state_t state;
  logic [PW-1:0] ph;
  logic [IW-1:0] idx, nk, lx, last;
  logic [LEN_W-1:0] len, clen;
  logic [LEN_W:0] shamt;
  logic [IR_W-1:0] ir_sr;
  logic [DR_W-1:0] dr_sr, cap;
  logic ph_end, cur_sh, nk_sh, nk_tms;
  // idx numbers the TCK pulses within the current segment; every segment's pulse 0 has TMS=1
  always_comb begin
    nk = idx + 1'b1;
    lx = IW'(len);
    clen = (cmd_len > LEN_W'(DR_W)) ? LEN_W'(DR_W) : cmd_len;
    shamt = (LEN_W + 1)'(DR_W) - {1'b0, len};
    ph_end = ph == PW'(DIV - 1);
    last = state == TLR ? IW'(5) : state == IR ? IW'(IR_W + 5) : lx + IW'(4);
    cur_sh = state == DR && idx >= IW'(3) && idx < lx + IW'(3);
    nk_sh = state == IR ? (nk >= IW'(4) && nk < IW'(IR_W + 4)) :
            (state == DR && nk >= IW'(3) && nk < lx + IW'(3));
    nk_tms = state == TLR ? nk != IW'(5) :
             state == IR ? (nk < IW'(2) || nk == IW'(IR_W + 3) || nk == IW'(IR_W + 4)) :
             (nk == lx + IW'(2) || nk == lx + IW'(3));
  end
  // captured bits enter at the MSB and are right-justified by shamt when the command completes
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= TLR;
      tck <= 1'b0;
      tms <= 1'b1;
      tdi <= 1'b0;
      ph <= '0;
      idx <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_dr <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (state == IDLE) begin
        if (cmd_valid) begin
          len <= clen;
          ir_sr <= cmd_ir;
          dr_sr <= cmd_dr;
          cap <= '0;
          ph <= '0;
          idx <= '0;
          tdi <= 1'b0;
          if (cmd_ir_en || clen != '0) begin
            state <= cmd_ir_en ? IR : DR;
            tms <= 1'b1;
            cmd_ready <= 1'b0;
          end else begin
            rsp_valid <= 1'b1;
            rsp_dr <= '0;
          end
        end
      end else if (!ph_end) begin
        ph <= ph + 1'b1;
      end else begin
        ph <= '0;
        tck <= !tck;
        if (!tck) begin
          if (cur_sh) cap <= {tdo, cap[DR_W-1:1]};
        end else if (idx != last) begin
          idx <= nk;
          tms <= nk_tms;
          tdi <= nk_sh && (state == IR ? ir_sr[0] : dr_sr[0]);
          if (nk_sh && state == IR) ir_sr <= ir_sr >> 1;
          if (nk_sh && state == DR) dr_sr <= dr_sr >> 1;
        end else begin
          idx <= '0;
          tdi <= 1'b0;
          if (state == IR && len != '0) begin
            state <= DR;
            tms <= 1'b1;
          end else begin
            state <= IDLE;
            cmd_ready <= 1'b1;
            if (state != TLR) begin
              rsp_valid <= 1'b1;
              rsp_dr <= cap >> shamt;
            end
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_jtag_scan_master.sv
// tb_jtag_scan_master: scoreboard bench for jtag_scan_master with a behavioural TAP (3-bit IR, 8-bit DR loopback)
module tb_jtag_scan_master;
  localparam int IR_W = 3, DR_W = 32, LEN_W = 6, DIV = 2;
  logic clk = 0, reset_n = 0, cmd_valid = 0, cmd_ir_en = 0;
  logic cmd_ready, rsp_valid, tck, tms, tdi, tdo;
  logic [IR_W-1:0] cmd_ir = '0;
  logic [DR_W-1:0] cmd_dr = '0, rsp_dr;
  logic [LEN_W-1:0] cmd_len = '0;
  always #5 clk = ~clk;
  jtag_scan_master #(.IR_W(IR_W), .DR_W(DR_W), .LEN_W(LEN_W), .DIV(DIV)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir_en(cmd_ir_en), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_dr(rsp_dr), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );
  typedef enum logic [3:0] {T_TLR, T_RTI, T_SDS, T_CDR, T_SDR, T_E1D, T_PDR, T_E2D, T_UDR,
                            T_SIS, T_CIR, T_SIR, T_E1I, T_PIR, T_E2I, T_UIR} tap_t;
  tap_t ts = T_TLR;
  logic [7:0] dsr = '0, dreg = 8'h3C;
  logic [2:0] isr = '0, ireg = '0;
  logic tdo_force = 0;
  function automatic tap_t nxt(tap_t s, logic m);
    case (s)
      T_TLR: return m ? T_TLR : T_RTI;
      T_RTI: return m ? T_SDS : T_RTI;
      T_SDS: return m ? T_SIS : T_CDR;
      T_CDR: return m ? T_E1D : T_SDR;
      T_SDR: return m ? T_E1D : T_SDR;
      T_E1D: return m ? T_UDR : T_PDR;
      T_PDR: return m ? T_E2D : T_PDR;
      T_E2D: return m ? T_UDR : T_SDR;
      T_UDR: return m ? T_SDS : T_RTI;
      T_SIS: return m ? T_TLR : T_CIR;
      T_CIR: return m ? T_E1I : T_SIR;
      T_SIR: return m ? T_E1I : T_SIR;
      T_E1I: return m ? T_UIR : T_PIR;
      T_PIR: return m ? T_E2I : T_PIR;
      T_E2I: return m ? T_UIR : T_SIR;
      default: return m ? T_SDS : T_RTI;
    endcase
  endfunction
  assign tdo = tdo_force | (ts == T_SDR ? dsr[0] : ts == T_SIR ? isr[0] : 1'b0);
  always @(posedge tck) begin
    case (ts)
      T_TLR: begin ireg <= '0; dreg <= 8'h3C; end
      T_CDR: dsr <= dreg;
      T_SDR: dsr <= {tdi, dsr[7:1]};
      T_UDR: dreg <= dsr;
      T_CIR: isr <= 3'b001;
      T_SIR: isr <= {tdi, isr[2:1]};
      T_UIR: ireg <= isr;
      default: ;
    endcase
    ts <= nxt(ts, tms);
  end
  typedef struct {logic [DR_W-1:0] rsp; int pulses; int lat;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  int cyc = 0, rises = 0, frise = -1, srise = -1;
  logic ptck = 0;
  logic [63:0] tms_log = '0;
  logic [7:0] exp_dr = 8'h3C;
  logic [2:0] exp_ir = '0;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (tck && !ptck) begin
      rises++;
      tms_log = {tms_log[62:0], tms};
      if (rises == 1) frise = cyc;
      if (rises == 2) srise = cyc;
    end
    ptck = tck;
    if (rsp_valid) begin
      if (sb.size() == 0) chk("spurious_rsp", 1, 0);
      else begin
        e = sb.pop_front();
        chk("rsp_dr", rsp_dr, e.rsp);
        chk("pulses", rises, e.pulses);
        chk("latency", cyc, e.lat);
        chk("ready_at_rsp", cmd_ready, 1);
        if (e.pulses > 0) chk("first_rise", frise, DIV + 1);
      end
    end
    if (reset_n && cmd_valid && cmd_ready) begin
      cyc = 0;
      rises = 0;
      frise = -1;
    end
  end
  function automatic logic [DR_W-1:0] expect_cmd(logic ir_en, logic [2:0] ir, logic [DR_W-1:0] dr, int l);
    logic [DR_W-1:0] o = '0;
    logic [7:0] sr = exp_dr;
    if (ir_en) exp_ir = ir;
    if (l > 0) begin
      for (int i = 0; i < l; i++) begin
        o[i] = tdo_force | sr[0];
        sr = {dr[i], sr[7:1]};
      end
      exp_dr = sr;
    end
    return o;
  endfunction
  task automatic wait_ready();
    int i;
    for (i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    chk("accept_timeout", i < 4000, 1);
  endtask
  task automatic wait_done();
    int i;
    for (i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    chk("done_timeout", i < 4000, 1);
  endtask
  task automatic send(logic ir_en, logic [2:0] ir, logic [DR_W-1:0] dr, logic [LEN_W-1:0] len, logic hold);
    exp_t e;
    int l = len > DR_W ? DR_W : int'(len);
    int p = (ir_en ? IR_W + 6 : 0) + (l > 0 ? l + 5 : 0);
    e.rsp = expect_cmd(ir_en, ir, dr, l);
    e.pulses = p;
    e.lat = p * 2 * DIV + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = 1;
    cmd_ir_en = ir_en;
    cmd_ir = ir;
    cmd_dr = dr;
    cmd_len = len;
    wait_ready();
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 0;
  endtask
  task automatic tlr_check();
    cyc = 0;
    rises = 0;
    frise = -1;
    srise = -1;
    tms_log = '0;
    for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
    #1;
    chk("tlr_ready_cyc", cyc, 6 * 2 * DIV + 1);
    chk("tlr_pulses", rises, 6);
    chk("tlr_tms", tms_log[5:0], 6'b111110);
    chk("tlr_period", srise - frise, 2 * DIV);
    chk("idle_tms", tms, 0);
    exp_dr = 8'h3C;
    exp_ir = '0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tck", tck, 0);
    chk("rst_tms", tms, 1);
    chk("rst_tdi", tdi, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_dr", rsp_dr, 0);
    @(posedge clk);
    #1 reset_n = 1;
    tlr_check();
    send(1, 3'b001, 32'h0000_00A5, 8, 0);
    wait_done();
    chk("tap_ir_1", ireg, 3'b001);
    chk("tap_dr_1", dreg, 8'hA5);
    tdo_force = 1;
    send(0, 3'b000, 32'h1234_5678, 40, 0);
    wait_done();
    tdo_force = 0;
    chk("tap_dr_clamp", dreg, exp_dr);
    send(0, 3'b111, 32'h0000_FFFF, 0, 0);
    wait_done();
    chk("tap_ir_untouched", ireg, exp_ir);
    send(1, 3'b110, 32'h0, 0, 0);
    wait_done();
    chk("tap_ir_only", ireg, 3'b110);
    send(1, 3'b011, 32'h0000_005A, 4, 1);
    send(0, 3'b000, 32'h0000_00C3, 8, 0);
    wait_done();
    chk("tap_ir_b2b", ireg, 3'b011);
    chk("tap_dr_b2b", dreg, exp_dr);
    send(0, 3'b000, 32'hDEAD_BEEF, 16, 0);
    for (int i = 0; i < 200 && rises < 5; i++) @(negedge clk);
    chk("midscan_reached", rises >= 5, 1);
    @(posedge clk);
    #1 reset_n = 0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    chk("abort_tck", tck, 0);
    chk("abort_tms", tms, 1);
    chk("abort_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    #1 reset_n = 1;
    tlr_check();
    chk("tap_ir_after_tlr", ireg, 3'b000);
    send(1, 3'b101, 32'h0000_BEEF, 16, 0);
    wait_done();
    chk("tap_ir_final", ireg, 3'b101);
    chk("tap_dr_final", dreg, exp_dr);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
